exmem_loader: RTL and testbench

Byte-wide external memory for the multicycle CPU, and the responder side of the controller's memory interface. It serves instruction-byte fetches, LB reads and SB writes on the `adr`/`writedata`/`memwrite` bus. After reset it first receives a program image over a valid/ready load port. Until loading completes it holds the CPU in reset through `cpu_hold`.

---
 rtl/exmem_loader.sv | 166 ++++++++++++++++
 tb/tb_exmem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_loader.sv
// exmem_loader: byte-wide external memory for the multicycle CPU, with a
// valid/ready program-image load port in front of it.
//
// After reset the block optionally clears the array (CLEAR), then accepts
// the program image (LOAD), then serves the CPU bus (RUN). The CPU is kept
// in reset through cpu_hold until the image is in place.
//
// Optional feature macro: EXMEM_CLEAR_EN
//   defined   -> every reset zeroes the whole array before loading.
//   undefined -> loading starts right after reset; unloaded bytes keep
//                whatever they held before.
//
// Load handshake: a byte transfers at a rising edge when ld_valid && ld_ready
// are both high. ld_ready is a registered decode of the state, so it never
// depends on ld_valid in the same cycle, and the loader may keep ld_valid high
// to stream one byte per cycle.
//
// state_dbg exposes the FSM state (0=CLEAR, 1=LOAD, 2=RUN) for observation.
module exmem_loader #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] adr,
  input  logic [WIDTH-1:0]  writedata,
  input  logic              memwrite,
  output logic [WIDTH-1:0]  memdata,
  input  logic              ld_valid,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic [AWIDTH:0]   ld_count,
  output logic [1:0]        state_dbg
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] PTR_MAX  = {AWIDTH{1'b1}};
  localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

`ifdef EXMEM_CLEAR_EN
  localparam state_t ST_ENTRY = ST_CLEAR;
`else
  localparam state_t ST_ENTRY = ST_LOAD;
`endif

  // Storage; deliberately not reset so that reset alone never alters contents.
  logic [WIDTH-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ld_ptr_q, ld_ptr_d;
  logic [AWIDTH:0]   ld_count_q, ld_count_d;
  logic              ld_ready_q, ld_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
`ifdef EXMEM_CLEAR_EN
  logic [AWIDTH-1:0] clr_ptr_q, clr_ptr_d;
`endif

  // Single memory write port shared by clear, load and CPU store.
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  // Next-state, pointer/counter updates and write-port selection.
  always_comb begin
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    ld_count_d = ld_count_q;
`ifdef EXMEM_CLEAR_EN
    clr_ptr_d  = clr_ptr_q;
`endif
    mem_we     = 1'b0;
    mem_waddr  = ld_ptr_q;
    mem_wdata  = ld_data;

    case (state_q)
`ifdef EXMEM_CLEAR_EN
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == PTR_MAX) begin
          state_d = ST_LOAD;
        end
      end
`endif
      ST_LOAD: begin
        // ld_ready is high throughout LOAD, so ld_valid alone means transfer.
        if (ld_valid) begin
          mem_we     = 1'b1;
          mem_waddr  = ld_ptr_q;
          mem_wdata  = ld_data;
          ld_count_d = ld_count_q + CNT_ONE;
          // The last slot ends the load; the pointer is left there rather
          // than wrapping back onto address 0.
          if (ld_last || (ld_ptr_q == PTR_MAX)) begin
            state_d = ST_RUN;
          end else begin
            ld_ptr_d = ld_ptr_q + PTR_ONE;
          end
        end
      end
      ST_RUN: begin
        if (memwrite) begin
          mem_we    = 1'b1;
          mem_waddr = adr;
          mem_wdata = writedata;
        end
      end
      default: begin
        state_d = ST_ENTRY;
      end
    endcase

    ld_ready_d = (state_d == ST_LOAD);
    cpu_hold_d = (state_d != ST_RUN);
  end

  // FSM, pointers, counter and registered handshake/hold outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ENTRY;
      ld_ptr_q   <= '0;
      ld_count_q <= '0;
      ld_ready_q <= (ST_ENTRY == ST_LOAD);
      cpu_hold_q <= 1'b1;
`ifdef EXMEM_CLEAR_EN
      clr_ptr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      ld_count_q <= ld_count_d;
      ld_ready_q <= ld_ready_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef EXMEM_CLEAR_EN
      clr_ptr_q  <= clr_ptr_d;
`endif
    end
  end

  // Array write; blocked while reset is held so reset never writes a byte.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Asynchronous read: the controller latches memdata in the same cycle it
  // presents the address. Outside RUN the CPU sees zeros.
  assign memdata   = (state_q == ST_RUN) ? mem[adr] : '0;
  assign ld_ready  = ld_ready_q;
  assign cpu_hold  = cpu_hold_q;
  assign ld_count  = ld_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_exmem_loader.sv
// tb_exmem_loader: directed bench for exmem_loader (AWIDTH=8, WIDTH=8).
// Inputs change 1 ns after the rising edge; outputs are sampled a further
// 1 ns later, well away from the next edge.
module tb_exmem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       memwrite;
  logic [7:0] memdata;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       cpu_hold;
  logic [8:0] ld_count;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

`ifdef EXMEM_CLEAR_EN
  localparam logic RDY_IN_RESET = 1'b0;
  localparam logic [7:0] EXP_0X10_AFTER_RELOAD = 8'h00;
`else
  localparam logic RDY_IN_RESET = 1'b1;
  localparam logic [7:0] EXP_0X10_AFTER_RELOAD = 8'h11;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  exmem_loader #(.WIDTH(8), .AWIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .memdata   (memdata),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_hold  (cpu_hold),
    .ld_count  (ld_count),
    .state_dbg (state_dbg)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    adr = a;
    #1;
    check(tag, {24'd0, memdata}, {24'd0, exp});
  endtask

  // Pulse reset and wait (bounded) until the block accepts load bytes.
  task automatic reset_and_wait();
    int n;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    while (!ld_ready && n < 400) begin
      step();
      n++;
    end
    check("ready_after_reset", {31'd0, ld_ready}, 32'd1);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    reset     = 1'b1;
    adr       = '0;
    writedata = '0;
    memwrite  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;

    // Outputs while reset is held.
    #2;
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_ld_count", {23'd0, ld_count}, 32'd0);
    check("rst_memdata",  {24'd0, memdata},  32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, {31'd0, RDY_IN_RESET});
    step();
    step();
    reset = 1'b0;
    begin
      int n = 0;
      while (!ld_ready && n < 400) begin
        step();
        n++;
      end
    end
    check("ready_after_first_reset", {31'd0, ld_ready}, 32'd1);

    // Load and hand-off.
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h05);
    load_byte(8'h20, 1'b0);
    load_byte(8'h01, 1'b0);
    load_byte(8'h00, 1'b0);
    check("hold_before_last", {31'd0, cpu_hold}, 32'd1);
    check("count_before_last", {23'd0, ld_count}, 32'd3);
    load_byte(8'h05, 1'b1);
    check("count_after_last", {23'd0, ld_count}, 32'd4);
    check("hold_after_last", {31'd0, cpu_hold}, 32'd0);
    check("ready_in_run", {31'd0, ld_ready}, 32'd0);
    check("state_run", {30'd0, state_dbg}, 32'd2);
    for (int a = 0; a < 4; a++) begin
      read_chk("load_readback", 8'(a), exp_q.pop_front());
    end

    // Bus write/read in RUN, including read-during-write of the same byte.
    bus_write(8'h40, 8'h3C);
    bus_write(8'h10, 8'h11);
    adr       = 8'h40;
    writedata = 8'hA5;
    memwrite  = 1'b1;
    #1;
    check("same_cycle_old", {24'd0, memdata}, 32'h3C);
    step();
    memwrite = 1'b0;
    check("store_visible", {24'd0, memdata}, 32'hA5);

    // Hold-off: loader bytes ignored in RUN.
    ld_valid = 1'b1;
    ld_data  = 8'h77;
    ld_last  = 1'b1;
    step();
    step();
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("run_ld_count_fixed", {23'd0, ld_count}, 32'd4);
    check("run_ready_low", {31'd0, ld_ready}, 32'd0);
    read_chk("run_ld_nowrite0", 8'h00, 8'h20);
    read_chk("run_ld_nowrite3", 8'h03, 8'h05);

    // Reset mid-load, with CPU stores attempted throughout LOAD.
    reset_and_wait();
    adr       = 8'h10;
    writedata = 8'hEE;
    memwrite  = 1'b1;
    load_byte(8'h51, 1'b0);
    load_byte(8'h52, 1'b0);
    check("midload_count", {23'd0, ld_count}, 32'd2);
    check("load_memdata_zero", {24'd0, memdata}, 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst_count", {23'd0, ld_count}, 32'd0);
    step();
    reset = 1'b0;
    begin
      int n = 0;
      while (!ld_ready && n < 400) begin
        step();
        n++;
      end
    end
    check("ready_after_midrst", {31'd0, ld_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h61 + i));
      load_byte(8'(8'h61 + i), (i == 4));
    end
    memwrite = 1'b0;
    check("reload_count", {23'd0, ld_count}, 32'd5);
    check("reload_hold", {31'd0, cpu_hold}, 32'd0);
    for (int a = 0; a < 5; a++) begin
      read_chk("reload_readback", 8'(a), exp_q.pop_front());
    end
    read_chk("load_store_ignored", 8'h10, EXP_0X10_AFTER_RELOAD);

    // Wrap: full 256-byte image without ld_last.
    reset_and_wait();
    for (int i = 0; i < 255; i++) begin
      load_byte(8'(i), 1'b0);
    end
    check("wrap_ready_255", {31'd0, ld_ready}, 32'd1);
    check("wrap_hold_255", {31'd0, cpu_hold}, 32'd1);
    check("wrap_count_255", {23'd0, ld_count}, 32'd255);
    load_byte(8'hFF, 1'b0);
    check("wrap_count_256", {23'd0, ld_count}, 32'd256);
    check("wrap_ready_low", {31'd0, ld_ready}, 32'd0);
    check("wrap_hold_low", {31'd0, cpu_hold}, 32'd0);
    read_chk("wrap_rd_00", 8'h00, 8'h00);
    read_chk("wrap_rd_10", 8'h10, 8'h10);
    read_chk("wrap_rd_7f", 8'h7F, 8'h7F);
    read_chk("wrap_rd_ff", 8'hFF, 8'hFF);

`ifdef EXMEM_CLEAR_EN
    // Clear on reset: preload 0x80, reset, count CLEAR cycles, reload.
    bus_write(8'h80, 8'hFF);
    read_chk("preload_80", 8'h80, 8'hFF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    begin
      int n = 0;
      while (!ld_ready && n < 400) begin
        step();
        n++;
      end
      check("clear_cycles", n, 32'd256);
    end
    load_byte(8'h42, 1'b1);
    read_chk("clear_rd_80", 8'h80, 8'h00);
    read_chk("clear_rd_00", 8'h00, 8'h42);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
